// File: rtl/mem_wb_stage.sv
// MEM stage with an internal little-endian data memory, fused with the MEM/WB
// pipeline register and a registered debug read port. Optional macro: MEM_MISALIGN_TRAP_EN.
module mem_wb_stage #(
    parameter int NBITS  = 32,
    parameter int RBITS  = 5,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [NBITS-1:0]  MEM_result,
    input  logic [NBITS-1:0]  MEM_Rt,
    input  logic [RBITS-1:0]  MEM_rd,
    input  logic [4:0]        MEM_sizecontrol,
    input  logic              MEM_memtoreg,
    input  logic              MEM_memread,
    input  logic              MEM_regwrite,
    input  logic              MEM_memwrite,
    input  logic              MEM_haltflag,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [NBITS-1:0]  WB_result,
    output logic [NBITS-1:0]  WB_readdata,
    output logic [RBITS-1:0]  WB_rd,
    output logic              WB_regwrite,
    output logic              WB_memtoreg,
    output logic              WB_haltflag,
    output logic              o_misalign,
    output logic [NBITS-1:0]  o_dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [NBITS-1:0]  mem [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_off;
    logic [1:0]        eff_off;
    logic              is_byte;
    logic              is_half;
    logic              is_unsigned;
    logic              advance;
    logic              mis_access;
    logic              store_en;
    logic [3:0]        lane_we;
    logic [NBITS-1:0]  wdata;
    logic [NBITS-1:0]  rd_word;
    logic [NBITS-1:0]  shifted;
    logic [NBITS-1:0]  ext_data;
    logic [NBITS-1:0]  load_data;
    logic              unused_bits;

    assign word_idx    = MEM_result[ADDR_W+1:2];
    assign byte_off    = MEM_result[1:0];
    assign is_byte     = (MEM_sizecontrol[1:0] == 2'b00);
    assign is_half     = (MEM_sizecontrol[1:0] == 2'b01);
    assign is_unsigned = MEM_sizecontrol[2];
    assign unused_bits = &{1'b0, MEM_sizecontrol[4:3], MEM_result[NBITS-1:ADDR_W+2]};

    // A halted pipeline stays frozen until reset, whatever i_enable says.
    assign advance = i_enable & ~WB_haltflag;

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_access = (MEM_memread | MEM_memwrite) &
                        ((is_half & byte_off[0]) |
                         (~is_byte & ~is_half & (byte_off != 2'b00)));
`else
    assign mis_access = 1'b0;
`endif

    // Halves are always aligned to addr[1] and words to lane 0; with the trap
    // enabled the offending instruction is squashed anyway.
    always_comb begin
        eff_off = 2'b00;
        if (is_byte) begin
            eff_off = byte_off;
        end else if (is_half) begin
            eff_off = {byte_off[1], 1'b0};
        end
    end

    always_comb begin
        lane_we = 4'b1111;
        wdata   = MEM_Rt;
        if (is_byte) begin
            lane_we = 4'b0001 << eff_off;
            wdata   = {4{MEM_Rt[7:0]}};
        end else if (is_half) begin
            lane_we = 4'b0011 << eff_off;
            wdata   = {2{MEM_Rt[15:0]}};
        end
    end

    // Gating with i_rst drops a store that coincides with the reset edge.
    assign store_en = MEM_memwrite & advance & ~mis_access & ~i_rst;

    always_ff @(posedge i_clk) begin
        if (store_en) begin
            for (int l = 0; l < 4; l++) begin
                if (lane_we[l]) begin
                    mem[word_idx][8*l +: 8] <= wdata[8*l +: 8];
                end
            end
        end
    end

    assign rd_word = mem[word_idx];
    assign shifted = rd_word >> {eff_off, 3'b000};

    always_comb begin
        ext_data = shifted;
        if (is_byte) begin
            ext_data = is_unsigned ? {24'h000000, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
        end else if (is_half) begin
            ext_data = is_unsigned ? {16'h0000, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
        end
    end

    assign load_data = MEM_memread ? ext_data : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            WB_result   <= '0;
            WB_readdata <= '0;
            WB_rd       <= '0;
            WB_regwrite <= 1'b0;
            WB_memtoreg <= 1'b0;
            WB_haltflag <= 1'b0;
            o_misalign  <= 1'b0;
        end else if (advance) begin
            WB_result   <= MEM_result;
            WB_readdata <= load_data;
            WB_rd       <= MEM_rd;
            WB_regwrite <= MEM_regwrite & ~(mis_access & MEM_memread);
            WB_memtoreg <= MEM_memtoreg;
            WB_haltflag <= MEM_haltflag;
            o_misalign  <= mis_access;
        end
    end

    // Debug port reads the pre-store word when a store hits the same edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_dbg_data <= '0;
        end else begin
            o_dbg_data <= mem[i_dbg_addr];
        end
    end

endmodule
